// File: rtl/mem_access_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port main memory.
// Latency: request sampled in IDLE -> done pulse WAIT_CYCLES+2 edges later; one access per WAIT_CYCLES+3 cycles.
// Backpressure: requesters hold req level until their done pulse; the loser stays pending. Optional macro MEM_ARB_ROUND_ROBIN_EN.
module mem_access_arbiter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_done,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        own;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        any_req;
  logic        grant_d;
  logic        last_wait;

  assign any_req   = f_req | d_req;
  assign last_wait = (cnt == WAIT_LAST);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_ptr holds the owner of the most recent grant (0 = F, 1 = D).
  logic rr_ptr;

  // Contested grants go to the port that was not served last.
  always_comb begin
    grant_d = d_req;
    if (d_req && f_req) begin
      grant_d = ~rr_ptr;
    end
  end

  // Pointer follows every grant, contested or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (state == IDLE && any_req) begin
      rr_ptr <= grant_d;
    end
  end
`else
  // Fixed priority: the data path always beats instruction fetch.
  always_comb begin
    grant_d = d_req;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and memory-side / completion outputs.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    f_done    = 1'b0;
    d_done    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if (last_wait) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        f_done    = ~own;
        d_done    = own;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign owner = own;

  // Grant latch, wait counter and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      own       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
      f_rdata   <= 16'h0000;
      d_rdata   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (any_req) begin
            // Operands are frozen here; later input changes are ignored.
            own       <= grant_d;
            lat_we    <= grant_d & d_we;
            lat_addr  <= grant_d ? d_addr : f_addr;
            lat_wdata <= grant_d ? d_wdata : 16'h0000;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (last_wait && !lat_we) begin
            if (own) begin
              d_rdata <= mem_rdata;
            end else begin
              f_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench: vector table on a zero-wait instance, hand sequences on a three-wait instance.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: requesters follow the hold-until-done protocol unless a test withdraws deliberately.
module tb_mem_access_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance a: WAIT_CYCLES = 0
  logic        a_f_req = 0, a_d_req = 0, a_d_we = 0;
  logic [15:0] a_f_addr = 0, a_d_addr = 0, a_d_wdata = 0, a_mem_rdata = 0;
  logic        a_f_done, a_d_done, a_mem_en, a_mem_we, a_busy, a_owner;
  logic [15:0] a_f_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;

  // instance b: WAIT_CYCLES = 3
  logic        b_f_req = 0, b_d_req = 0, b_d_we = 0;
  logic [15:0] b_f_addr = 0, b_d_addr = 0, b_d_wdata = 0, b_mem_rdata = 0;
  logic        b_f_done, b_d_done, b_mem_en, b_mem_we, b_busy, b_owner;
  logic [15:0] b_f_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

  mem_access_arbiter #(.WAIT_CYCLES(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .f_req(a_f_req), .f_addr(a_f_addr), .f_done(a_f_done), .f_rdata(a_f_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_done(a_d_done), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
  );

  mem_access_arbiter #(.WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .f_req(b_f_req), .f_addr(b_f_addr), .f_done(b_f_done), .f_rdata(b_f_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_done(b_d_done), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  typedef struct {
    logic        f_req;
    logic [15:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] mrd;
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        fdone;
    logic        ddone;
    logic [15:0] frd;
    logic [15:0] drd;
    logic        busy;
    logic        owner;
  } vec_t;

  vec_t vecs [12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    int   n;
    int   pulses;
    int   grants;
    logic prev_en;
    logic got [4];
    logic exp_own [4];

    //         f  f_addr    d  we d_addr    d_wdata   mrd       en we addr      wdata     fd dd frd       drd       bsy own
    vecs[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5A5A, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h5A5A, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 16'h5A5A, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h5A5A, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 16'h0030, 1'b1, 1'b1, 16'h0040, 16'h1111, 16'h7777, 1'b1, 1'b1, 16'h0040, 16'h1111, 1'b0, 1'b0, 16'hBEEF, 16'h5A5A, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 16'h0030, 1'b1, 1'b1, 16'h0040, 16'h1111, 16'h7777, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'h5A5A, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7777, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h5A5A, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7777, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h5A5A, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7777, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h7777, 16'h5A5A, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h7777, 16'h5A5A, 1'b0, 1'b0};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst a_mem_en", 16'(a_mem_en), 16'h0);
    chk("rst a_busy", 16'(a_busy), 16'h0);
    chk("rst a_owner", 16'(a_owner), 16'h0);
    chk("rst b_mem_addr", b_mem_addr, 16'h0);
    chk("rst b_f_rdata", b_f_rdata, 16'h0);
    chk("rst b_d_done", 16'(b_d_done), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- vector table on instance a ----
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      a_f_req     = vecs[i].f_req;
      a_f_addr    = vecs[i].f_addr;
      a_d_req     = vecs[i].d_req;
      a_d_we      = vecs[i].d_we;
      a_d_addr    = vecs[i].d_addr;
      a_d_wdata   = vecs[i].d_wdata;
      a_mem_rdata = vecs[i].mrd;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mem_en", i), 16'(a_mem_en), 16'(vecs[i].en));
      chk($sformatf("v%0d mem_we", i), 16'(a_mem_we), 16'(vecs[i].we));
      chk($sformatf("v%0d mem_addr", i), a_mem_addr, vecs[i].addr);
      chk($sformatf("v%0d mem_wdata", i), a_mem_wdata, vecs[i].wdata);
      chk($sformatf("v%0d f_done", i), 16'(a_f_done), 16'(vecs[i].fdone));
      chk($sformatf("v%0d d_done", i), 16'(a_d_done), 16'(vecs[i].ddone));
      chk($sformatf("v%0d f_rdata", i), a_f_rdata, vecs[i].frd);
      chk($sformatf("v%0d d_rdata", i), a_d_rdata, vecs[i].drd);
      chk($sformatf("v%0d busy", i), 16'(a_busy), 16'(vecs[i].busy));
      if (vecs[i].busy) begin
        chk($sformatf("v%0d owner", i), 16'(a_owner), 16'(vecs[i].owner));
      end
    end

    // ---- instance b: store with 3 wait states ----
    b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 16'h00A0; b_d_wdata = 16'h1234;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("st c%0d mem_en", k), 16'(b_mem_en), 16'h1);
      chk($sformatf("st c%0d mem_we", k), 16'(b_mem_we), 16'h1);
      chk($sformatf("st c%0d mem_addr", k), b_mem_addr, 16'h00A0);
      chk($sformatf("st c%0d mem_wdata", k), b_mem_wdata, 16'h1234);
      chk($sformatf("st c%0d d_done", k), 16'(b_d_done), 16'h0);
    end
    @(posedge clk);
    #1;
    chk("st d_done", 16'(b_d_done), 16'h1);
    chk("st mem_en off", 16'(b_mem_en), 16'h0);
    chk("st mem_we off", 16'(b_mem_we), 16'h0);
    chk("st d_rdata kept", b_d_rdata, 16'h0000);
    b_d_req = 1'b0; b_d_we = 1'b0;
    @(posedge clk);
    #1;
    chk("st idle busy", 16'(b_busy), 16'h0);
    chk("st idle d_done", 16'(b_d_done), 16'h0);

    // ---- instance b: fetch withdrawn mid-access ----
    b_f_req = 1'b1; b_f_addr = 16'h0077; b_mem_rdata = 16'h4321;
    repeat (2) @(posedge clk);
    #1;
    b_f_req = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (b_f_done) pulses++;
    end
    chk("drop f_done pulses", 16'(pulses), 16'd1);
    chk("drop busy after", 16'(b_busy), 16'h0);
    chk("drop f_rdata", b_f_rdata, 16'h4321);

    // ---- instance b: reset during second access cycle ----
    b_f_req = 1'b1; b_f_addr = 16'h0055; b_mem_rdata = 16'hCAFE;
    repeat (2) @(posedge clk);
    #1;
    chk("rm pre mem_en", 16'(b_mem_en), 16'h1);
    rst_n = 1'b0;
    b_f_req = 1'b0;
    #1;
    chk("rm mem_en", 16'(b_mem_en), 16'h0);
    chk("rm mem_addr", b_mem_addr, 16'h0000);
    chk("rm busy", 16'(b_busy), 16'h0);
    chk("rm f_rdata", b_f_rdata, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (b_f_done || b_d_done) pulses++;
    end
    chk("rm no done", 16'(pulses), 16'd0);
    b_f_req = 1'b1; b_f_addr = 16'h0066;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (b_f_done) break;
    end
    b_f_req = 1'b0;
    chk("rm next latency", 16'(n), 16'd5);
    chk("rm next f_rdata", b_f_rdata, 16'hCAFE);

    // ---- instance a: both ports held for four grants ----
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    a_d_we = 1'b0; a_d_addr = 16'h0100; a_f_addr = 16'h0101; a_mem_rdata = 16'h0000;
    a_f_req = 1'b1; a_d_req = 1'b1;
    grants  = 0;
    prev_en = 1'b0;
    for (int k = 0; k < 60 && grants < 4; k++) begin
      @(posedge clk);
      #1;
      if (a_mem_en && !prev_en) begin
        got[grants] = a_owner;
        grants++;
      end
      prev_en = a_mem_en;
    end
    a_f_req = 1'b0; a_d_req = 1'b0;
    chk("rr grant count", 16'(grants), 16'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < grants) begin
        chk($sformatf("rr owner %0d", k), 16'(got[k]), 16'(exp_own[k]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single-port main memory between two requesters: instruction fetch (port F) and the LOAD/STORE data path (port D).
- Sequences each access as address phase, fixed wait states, then a one-cycle completion pulse.
- Drives mem_addr/mem_wdata/mem_we toward memory and returns read data that feeds MDR.
- Sits between the CPU control unit and the memory interface.

Parameters:
- WAIT_CYCLES, 0, extra memory wait states per access; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch request, level
- f_addr  in  16  fetch address
- f_done  out  1  one-cycle pulse: fetch complete
- f_rdata  out  16  fetched instruction word
- d_req  in  1  data request, level
- d_we  in  1  1 = store, 0 = load
- d_addr  in  16  data address (MAR)
- d_wdata  in  16  store data (MDR)
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  16  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- busy  out  1  high in any non-IDLE state
- owner  out  1  0 = F, 1 = D; meaningful while busy

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0; state IDLE; wait counter 0; rdata registers 0; round-robin pointer 0 (D favoured).
- States:
  - IDLE: sample requests; go to ACCESS if any request is present.
  - ACCESS: lasts WAIT_CYCLES+1 cycles.
  - DONE: lasts 1 cycle, then returns to IDLE.
- Grant, at the IDLE→ACCESS edge:
  - Latch owner, address, we and wdata from the winning port.
  - Inputs are ignored for the rest of the transaction.
  - Default priority is fixed: D over F when both are requesting.
- ACCESS outputs:
  - mem_en = 1.
  - mem_addr/mem_we/mem_wdata come from the latched values.
  - Counter starts at 0 and increments each cycle.
  - On the cycle where counter == WAIT_CYCLES: capture mem_rdata into the owner's rdata register (loads only; stores leave it unchanged), then move to DONE.
- DONE outputs:
  - mem_en = 0 and mem_we = 0.
  - Owner's done = 1 for exactly this cycle; the other port's done stays 0.
  - rdata stays valid from DONE until that port's next completion.
- Latency:
  - Request seen in IDLE at edge E → done high in cycle E+WAIT_CYCLES+2.
  - Back-to-back throughput: one access per WAIT_CYCLES+3 cycles, including the mandatory IDLE bubble.
- Requester protocol:
  - Hold req and operands until done.
  - Drop req on the edge that ends the done cycle.
  - req still high in the following IDLE cycle is treated as a new request.
- Requester withdraws req mid-transaction: the access still completes and done is still pulsed.
- Both requests arrive in the same cycle: D is granted. F stays pending and is granted on the next IDLE cycle if still asserted.
- Reset mid-transaction: immediate abort; outputs go to reset values; no done is issued. A store may or may not have reached memory.
- mem_we is never high outside ACCESS.
- Counter width is 4 bits; no wrap is possible within the legal WAIT_CYCLES range.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit pointer records the last owner at each grant.
  - On a contested grant, the port that was not served last wins.
  - The pointer updates only on grants; uncontested grants update it too.
- Undefined: fixed D-over-F priority; no pointer register exists.

Test Plan:
- WAIT_CYCLES=0, F reads 0x0010 with mem_rdata=0xBEEF → mem_en high 1 cycle, f_done pulses at request edge +2, f_rdata=0xBEEF, d_done stays 0.
- WAIT_CYCLES=3, D stores 0x1234 to 0x00A0 → mem_en and mem_we high exactly 4 cycles with mem_addr=0x00A0, mem_wdata=0x1234; d_done at +5; d_rdata unchanged.
- f_req and d_req both rise in the same cycle, default build → D served first, F served next; 1 IDLE cycle between d_done and the second mem_en.
- Same stimulus, MEM_ARB_ROUND_ROBIN_EN defined, both ports held requesting for 4 transactions → owner sequence D,F,D,F.
- rst_n low during the 2nd ACCESS cycle with WAIT_CYCLES=3 → all outputs 0 asynchronously; no done pulse after release; next request is served normally.
- F drops f_req mid-ACCESS → f_done still pulses once; the arbiter returns to IDLE and stays idle.
